// File: rtl/axi2per_sched_pkg.sv
// Shared types and constants for the AXI-to-peripheral request scheduler.
package axi2per_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_REQ   = 2'd1,
        WR_REQ   = 2'd2,
        WAIT_RSP = 2'd3
    } sched_state_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam int PER_DATA_WIDTH = 32;
    localparam int PER_BE_WIDTH   = 4;

    // The peripheral is 32 bits wide, so wider beats step by at most one word.
    function automatic logic [1:0] cap_size(input logic [2:0] size);
        return (size > 3'd2) ? 2'd2 : size[1:0];
    endfunction

endpackage

// File: rtl/axi2per_rr_arb2.sv
// Two-requester round-robin arbiter; req_i[0] is read, req_i[1] is write.
module axi2per_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic rr_q, rr_d;

    // The pointer only moves on a real conflict, so it always names the last loser.
    always_comb begin
        gnt_o = 2'b00;
        rr_d  = rr_q;
        if (en_i) begin
            unique case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11: begin
                    gnt_o = rr_q ? 2'b10 : 2'b01;
                    rr_d  = ~rr_q;
                end
                default: gnt_o = 2'b00;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) rr_q <= 1'b0;
        else       rr_q <= rr_d;
    end

endmodule

// File: rtl/axi2per_req_sched.sv
// Request-side scheduler: accepts AR/AW round-robin and unrolls each burst into single 32-bit peripheral accesses.
module axi2per_req_sched
    import axi2per_sched_pkg::*;
#(
    parameter int PER_ADDR_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 3,
    parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH/8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      aw_valid_i,
    output logic                      aw_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0] aw_addr_i,
    input  logic [7:0]                aw_len_i,
    input  logic [2:0]                aw_size_i,
    input  logic [1:0]                aw_burst_i,
    input  logic [AXI_ID_WIDTH-1:0]   aw_id_i,
    input  logic                      ar_valid_i,
    output logic                      ar_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0] ar_addr_i,
    input  logic [7:0]                ar_len_i,
    input  logic [2:0]                ar_size_i,
    input  logic [1:0]                ar_burst_i,
    input  logic [AXI_ID_WIDTH-1:0]   ar_id_i,
    input  logic                      w_valid_i,
    output logic                      w_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0] w_data_i,
    input  logic [AXI_STRB_WIDTH-1:0] w_strb_i,
    input  logic                      w_last_i,
    output logic                      per_master_req_o,
    input  logic                      per_master_gnt_i,
    output logic [PER_ADDR_WIDTH-1:0] per_master_add_o,
    output logic                      per_master_we_o,
    output logic [PER_DATA_WIDTH-1:0] per_master_wdata_o,
    output logic [PER_BE_WIDTH-1:0]   per_master_be_o,
    output logic                      trans_req_o,
    output logic                      trans_we_o,
    output logic [AXI_ID_WIDTH-1:0]   trans_id_o,
    output logic [AXI_ADDR_WIDTH-1:0] trans_add_o,
    output logic                      trans_last_o,
    input  logic                      trans_r_valid_i
);

    sched_state_e              state_q, state_d, state_eff;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [1:0]                size_q, size_d;
    logic                      fixed_q, fixed_d;
    logic                      we_q, we_d;
    logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
    logic [1:0]                acc_gnt;
    logic                      issue;
    logic                      unused_w_last;

    // Beat count is authoritative; w_last is not needed for sequencing.
    assign unused_w_last = w_last_i;

    // While reset is held every output behaves as in IDLE with no handshake possible.
    assign state_eff = rst_i ? IDLE : state_q;

    axi2per_rr_arb2 u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (!rst_i && (state_q == IDLE)),
        .req_i ({aw_valid_i, ar_valid_i}),
        .gnt_o (acc_gnt)
    );

    assign ar_ready_o = acc_gnt[0];
    assign aw_ready_o = acc_gnt[1];

    always_comb begin
        state_d            = state_q;
        addr_d             = addr_q;
        cnt_d              = cnt_q;
        size_d             = size_q;
        fixed_d            = fixed_q;
        we_d               = we_q;
        id_d               = id_q;
        issue              = 1'b0;
        per_master_req_o   = 1'b0;
        per_master_add_o   = '0;
        per_master_we_o    = 1'b0;
        per_master_wdata_o = '0;
        per_master_be_o    = '0;
        w_ready_o          = 1'b0;

        unique case (state_eff)
            IDLE: begin
                if (ar_ready_o) begin
                    addr_d  = ar_addr_i;
                    cnt_d   = ar_len_i;
                    size_d  = cap_size(ar_size_i);
                    fixed_d = (ar_burst_i == BURST_FIXED);
                    id_d    = ar_id_i;
                    we_d    = 1'b0;
                    state_d = RD_REQ;
                end else if (aw_ready_o) begin
                    addr_d  = aw_addr_i;
                    cnt_d   = aw_len_i;
                    size_d  = cap_size(aw_size_i);
                    fixed_d = (aw_burst_i == BURST_FIXED);
                    id_d    = aw_id_i;
                    we_d    = 1'b1;
                    state_d = WR_REQ;
                end
            end
            RD_REQ: begin
                per_master_req_o = 1'b1;
                per_master_add_o = addr_q[PER_ADDR_WIDTH-1:0];
                per_master_be_o  = 4'hF;
                if (per_master_gnt_i) begin
                    issue   = 1'b1;
                    state_d = WAIT_RSP;
                end
            end
            WR_REQ: begin
                per_master_req_o = w_valid_i;
                per_master_we_o  = 1'b1;
                per_master_add_o = addr_q[PER_ADDR_WIDTH-1:0];
                // addr[2] picks which 32-bit half of the 64-bit W beat this access carries.
                if (addr_q[2]) begin
                    per_master_wdata_o = w_data_i[63:32];
                    per_master_be_o    = w_strb_i[7:4];
                end else begin
                    per_master_wdata_o = w_data_i[31:0];
                    per_master_be_o    = w_strb_i[3:0];
                end
                if (w_valid_i && per_master_gnt_i) begin
                    w_ready_o = 1'b1;
                    issue     = 1'b1;
                    state_d   = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (trans_r_valid_i) begin
                    if (cnt_q == 8'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        addr_d  = fixed_q ? addr_q : addr_q + (AXI_ADDR_WIDTH'(1) << size_q);
                        state_d = we_q ? WR_REQ : RD_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        trans_req_o  = issue;
        trans_we_o   = issue & we_q;
        trans_id_o   = issue ? id_q : '0;
        trans_add_o  = issue ? addr_q : '0;
        trans_last_o = issue & (cnt_q == 8'd0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            fixed_q <= 1'b0;
            we_q    <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            fixed_q <= fixed_d;
            we_q    <= we_d;
            id_q    <= id_d;
        end
    end

endmodule

// File: tb/tb_axi2per_req_sched.sv
// Self-checking bench for axi2per_req_sched: table of bursts, contention, stall and reset sequences.
module tb_axi2per_req_sched;
    import axi2per_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        aw_valid_i, aw_ready_o, ar_valid_i, ar_ready_o;
    logic [31:0] aw_addr_i, ar_addr_i;
    logic [7:0]  aw_len_i, ar_len_i;
    logic [2:0]  aw_size_i, ar_size_i, aw_id_i, ar_id_i;
    logic [1:0]  aw_burst_i, ar_burst_i;
    logic        w_valid_i, w_ready_o, w_last_i;
    logic [63:0] w_data_i;
    logic [7:0]  w_strb_i;
    logic        per_master_req_o, per_master_gnt_i, per_master_we_o;
    logic [31:0] per_master_add_o, per_master_wdata_o;
    logic [3:0]  per_master_be_o;
    logic        trans_req_o, trans_we_o, trans_last_o, trans_r_valid_i;
    logic [2:0]  trans_id_o;
    logic [31:0] trans_add_o;

    axi2per_req_sched dut (
        .clk_i(clk), .rst_i(rst_i),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i),
        .aw_size_i(aw_size_i), .aw_burst_i(aw_burst_i), .aw_id_i(aw_id_i),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i),
        .ar_size_i(ar_size_i), .ar_burst_i(ar_burst_i), .ar_id_i(ar_id_i),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i), .w_strb_i(w_strb_i),
        .w_last_i(w_last_i),
        .per_master_req_o(per_master_req_o), .per_master_gnt_i(per_master_gnt_i),
        .per_master_add_o(per_master_add_o), .per_master_we_o(per_master_we_o),
        .per_master_wdata_o(per_master_wdata_o), .per_master_be_o(per_master_be_o),
        .trans_req_o(trans_req_o), .trans_we_o(trans_we_o), .trans_id_o(trans_id_o),
        .trans_add_o(trans_add_o), .trans_last_o(trans_last_o), .trans_r_valid_i(trans_r_valid_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [2:0]  id;
        logic [63:0] wdata;
        logic [63:0] wstep;
        logic [7:0]  strb;
        logic [31:0] exp_step;
    } txn_t;

    typedef struct {
        logic        we;
        logic [2:0]  id;
        logic [31:0] addr;
        logic        last;
        logic [3:0]  be;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  strb;
    } wbeat_t;

    beat_t  sb[$];
    wbeat_t wq[$];
    int     n_cmp = 0, n_err = 0, n_trans = 0;
    bit     gnt_allow = 1'b1, rsp_pend = 1'b0, w_took = 1'b0, rr_m = 1'b0;
    txn_t   tbl[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected beats for one burst: address advances by the table's exp_step.
    function automatic void push_txn(input txn_t t);
        logic [31:0] a;
        a = t.addr;
        for (int i = 0; i <= int'(t.len); i++) begin
            beat_t       b;
            wbeat_t      w;
            logic [63:0] d;
            d       = t.wdata + 64'(i) * t.wstep;
            b.we    = t.is_wr;
            b.id    = t.id;
            b.addr  = a;
            b.last  = (i == int'(t.len));
            b.be    = t.is_wr ? (a[2] ? t.strb[7:4] : t.strb[3:0]) : 4'hF;
            b.wdata = t.is_wr ? (a[2] ? d[63:32] : d[31:0]) : 32'h0;
            sb.push_back(b);
            if (t.is_wr) begin
                w.data = d;
                w.strb = t.strb;
                wq.push_back(w);
            end
            a = a + t.exp_step;
        end
    endfunction

    // Peripheral + response agent: grants, answers one cycle after each access, feeds W beats, scores accesses.
    initial begin
        beat_t e;
        per_master_gnt_i = 1'b0;
        trans_r_valid_i  = 1'b0;
        w_valid_i        = 1'b0;
        w_data_i         = '0;
        w_strb_i         = '0;
        w_last_i         = 1'b0;
        forever begin
            @(negedge clk);
            if (w_took && wq.size() > 0) void'(wq.pop_front());
            trans_r_valid_i = rsp_pend;
            rsp_pend        = 1'b0;
            w_valid_i       = (wq.size() > 0);
            if (wq.size() > 0) begin
                w_data_i = wq[0].data;
                w_strb_i = wq[0].strb;
                w_last_i = (wq.size() == 1);
            end
            #1;
            per_master_gnt_i = per_master_req_o && gnt_allow;
            #1;
            w_took = w_ready_o;
            if (trans_req_o) begin
                rsp_pend = 1'b1;
                n_trans++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_trans: got access at %h, expected none", trans_add_o);
                end else begin
                    e = sb.pop_front();
                    check("trans_hdr",
                          {per_master_we_o, trans_we_o, trans_id_o, trans_last_o, per_master_be_o},
                          {e.we, e.we, e.id, e.last, e.be});
                    check("trans_addr", {trans_add_o, per_master_add_o}, {e.addr, e.addr});
                    if (e.we) check("wdata", per_master_wdata_o, e.wdata);
                end
            end
        end
    end

    task automatic chk_zero(input string name);
        check({name, "_ctrl"},
              {per_master_req_o, per_master_we_o, per_master_be_o, trans_req_o, trans_we_o,
               trans_last_o, trans_id_o, w_ready_o, ar_ready_o, aw_ready_o}, 64'h0);
        check({name, "_data"}, {per_master_add_o, per_master_wdata_o}, 64'h0);
        check({name, "_tadd"}, trans_add_o, 64'h0);
    endtask

    task automatic issue(input txn_t t, input bit chk_lat);
        bit ok;
        ok = 1'b0;
        push_txn(t);
        @(negedge clk);
        if (t.is_wr) begin
            aw_valid_i = 1'b1; aw_addr_i = t.addr; aw_len_i = t.len;
            aw_size_i = t.size; aw_burst_i = t.burst; aw_id_i = t.id;
        end else begin
            ar_valid_i = 1'b1; ar_addr_i = t.addr; ar_len_i = t.len;
            ar_size_i = t.size; ar_burst_i = t.burst; ar_id_i = t.id;
        end
        for (int c = 0; c < 50; c++) begin
            #3;
            if (t.is_wr ? aw_ready_o : ar_ready_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept", 64'(ok), 64'h1);
        if (ok) @(posedge clk);
        #1;
        ar_valid_i = 1'b0;
        aw_valid_i = 1'b0;
        if (ok && chk_lat) check("req_latency", 64'(per_master_req_o), 64'h1);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            #3;
            if (sb.size() == 0 && wq.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL burst_timeout: got %0d beats pending, expected 0", sb.size());
            sb.delete();
            wq.delete();
        end
        repeat (2) @(negedge clk);
        #3;
    endtask

    // Both AR and AW held valid across n accepts; each accept must go to the side rr_m points at.
    task automatic contend(input int n);
        txn_t rd, wr;
        bit   ok;
        rd = '{1'b0, 32'h9000, 8'd0, 3'd2, BURST_INCR, 3'd1, 64'h0, 64'h0, 8'h00, 32'd4};
        wr = '{1'b1, 32'hA000, 8'd0, 3'd2, BURST_WRAP, 3'd2, 64'h1234_5678_9ABC_DEF0, 64'h0, 8'hFF, 32'd4};
        @(negedge clk);
        ar_valid_i = 1'b1; ar_addr_i = rd.addr; ar_len_i = rd.len; ar_size_i = rd.size;
        ar_burst_i = rd.burst; ar_id_i = rd.id;
        aw_valid_i = 1'b1; aw_addr_i = wr.addr; aw_len_i = wr.len; aw_size_i = wr.size;
        aw_burst_i = wr.burst; aw_id_i = wr.id;
        for (int k = 0; k < n; k++) begin
            ok = 1'b0;
            for (int c = 0; c < 50; c++) begin
                #3;
                if (ar_ready_o || aw_ready_o) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!ok) begin
                n_cmp++;
                n_err++;
                $display("FAIL contend_timeout: got no ready, expected one at accept %0d", k);
                break;
            end
            check("rr_order", {ar_ready_o, aw_ready_o}, rr_m ? 64'h1 : 64'h2);
            push_txn(rr_m ? wr : rd);
            rr_m = ~rr_m;
            @(posedge clk);
            #1;
            if (k == n - 1) begin
                ar_valid_i = 1'b0;
                aw_valid_i = 1'b0;
            end
            @(negedge clk);
        end
        ar_valid_i = 1'b0;
        aw_valid_i = 1'b0;
        wait_done();
    endtask

    initial begin
        txn_t st, rt;
        int   c0;
        bit   ok;
        rst_i = 1'b1;
        ar_valid_i = 1'b0; ar_addr_i = '0; ar_len_i = '0; ar_size_i = '0; ar_burst_i = '0; ar_id_i = '0;
        aw_valid_i = 1'b0; aw_addr_i = '0; aw_len_i = '0; aw_size_i = '0; aw_burst_i = '0; aw_id_i = '0;

        tbl[0] = '{1'b0, 32'h1000,      8'd0, 3'd2, BURST_INCR,  3'd5, 64'h0, 64'h0, 8'h00, 32'd4};
        tbl[1] = '{1'b1, 32'h2000,      8'd1, 3'd2, BURST_INCR,  3'd3, 64'hBBBB_BBBB_AAAA_AAAA, 64'h0, 8'hFF, 32'd4};
        tbl[2] = '{1'b0, 32'h3008,      8'd3, 3'd2, BURST_FIXED, 3'd1, 64'h0, 64'h0, 8'h00, 32'd0};
        tbl[3] = '{1'b1, 32'h4004,      8'd2, 3'd1, BURST_INCR,  3'd2, 64'h1111_2222_3333_4444,
                   64'h0000_0001_0000_0001, 8'h3C, 32'd2};
        tbl[4] = '{1'b0, 32'h5000,      8'd2, 3'd3, BURST_WRAP,  3'd6, 64'h0, 64'h0, 8'h00, 32'd4};
        tbl[5] = '{1'b0, 32'hFFFF_FFFC, 8'd1, 3'd2, BURST_INCR,  3'd7, 64'h0, 64'h0, 8'h00, 32'd4};
        tbl[6] = '{1'b1, 32'h6000,      8'd0, 3'd0, BURST_FIXED, 3'd4, 64'h5555_6666_7777_8888, 64'h0, 8'h0F, 32'd0};

        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_i = 1'b0;
        @(negedge clk);
        #3;
        chk_zero("idle");

        for (int i = 0; i < 7; i++) begin
            issue(tbl[i], 1'b1);
            wait_done();
        end

        contend(4);

        // Grant withheld: the write request must hold steady with no W consumption.
        st = '{1'b1, 32'h7000, 8'd0, 3'd2, BURST_INCR, 3'd3, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 8'hFF, 32'd4};
        gnt_allow = 1'b0;
        issue(st, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #3;
            check("stall_ctrl", {per_master_req_o, w_ready_o, trans_req_o, per_master_be_o}, {1'b1, 1'b0, 1'b0, 4'hF});
            check("stall_add_data", {per_master_add_o, per_master_wdata_o}, {32'h7000, 32'hCAFE_F00D});
        end
        gnt_allow = 1'b1;
        wait_done();

        contend(1);

        // Reset in WAIT_RSP of the second beat of a 4-beat read.
        rt = '{1'b0, 32'h8000, 8'd3, 3'd2, BURST_INCR, 3'd2, 64'h0, 64'h0, 8'h00, 32'd4};
        c0 = n_trans;
        ok = 1'b0;
        issue(rt, 1'b1);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            #3;
            if (n_trans >= c0 + 2) begin
                ok = 1'b1;
                break;
            end
        end
        check("reach_beat2", 64'(ok), 64'h1);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("midburst_reset");
        rst_i = 1'b0;
        sb.delete();
        wq.delete();
        rr_m = 1'b0;
        @(negedge clk);
        #3;
        chk_zero("post_reset_idle");

        issue(tbl[0], 1'b1);
        wait_done();
        contend(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
